// File: rtl/canvas_pkg.sv
// canvas_pkg: constants and types shared by the paint-canvas store.
//   color_code_t  : 4-bit pixel colour code
//   CANVAS_*      : canvas placement and size in beam coordinates
//   CLEAR_CODE    : colour written by a canvas clear (white)
//   clear_state_t : clear sequencer states
package canvas_pkg;

    typedef logic [3:0] color_code_t;

    localparam int CANVAS_X0    = 100;
    localparam int CANVAS_Y0    = 100;
    localparam int CANVAS_W     = 440;
    localparam int CANVAS_H     = 280;
    localparam int CANVAS_DEPTH = CANVAS_W * CANVAS_H;
    localparam int ADDR_W       = 17;

    localparam color_code_t CLEAR_CODE = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clear_state_t;

endpackage

// File: rtl/canvas_ram.sv
// canvas_ram: simple dual-port canvas memory, one write port and one
// registered read port. Read-during-write to the same address returns the
// old contents. The array itself is not reset; only the read register is,
// so the mapper sees a defined colour straight out of reset.
//   i_clk, i_rst          : clock, async active-high reset (read reg only)
//   i_we/i_waddr/i_wdata  : write port
//   i_re/i_raddr          : read enable/address; o_rdata holds when i_re=0
module canvas_ram #(
    parameter int          DEPTH   = 123200,
    parameter int          ADDR_W  = 17,
    parameter logic [3:0]  RST_VAL = 4'b0100
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [3:0]        i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [3:0]        o_rdata
);

    logic [3:0] r_mem [DEPTH];
    logic [3:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_q <= RST_VAL;
        else if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/canvas_store.sv
// canvas_store: owns the paint canvas RAM for the VGA colour mapper.
//   vgaClk, Reset      : pixel clock, async active-high reset
//   DrawX, DrawY       : current beam position
//   ram_read           : raster read strobe (canvas pixels + prefetch column)
//   ram_write, ramIn*  : write-back strobe; data arrives one cycle later
//   clear_req          : start whole-canvas clear (edge-armed level)
//   ramOut, ramOut2    : colour code of the pixel under the beam
//   clear_busy         : clear sequence in progress
// Addressing is built from a per-line base plus running pointers, so no
// multiplier is needed.
module canvas_store #(
    parameter int         CANVAS_X0  = canvas_pkg::CANVAS_X0,
    parameter int         CANVAS_Y0  = canvas_pkg::CANVAS_Y0,
    parameter int         CANVAS_W   = canvas_pkg::CANVAS_W,
    parameter int         CANVAS_H   = canvas_pkg::CANVAS_H,
    parameter logic [3:0] CLEAR_CODE = canvas_pkg::CLEAR_CODE,
    parameter int         ADDR_W     = canvas_pkg::ADDR_W
) (
    input  logic       vgaClk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       ram_read,
    input  logic       ram_write,
    input  logic [1:0] ramIn,
    input  logic [1:0] ramIn2,
    input  logic       clear_req,
    output logic [1:0] ramOut,
    output logic [1:0] ramOut2,
    output logic       clear_busy
);

    import canvas_pkg::*;

    localparam int DEPTH = CANVAS_W * CANVAS_H;

    localparam logic [9:0] L_X0     = 10'(CANVAS_X0);
    localparam logic [9:0] L_XPRE   = 10'(CANVAS_X0 - 1);
    localparam logic [9:0] L_XLAST  = 10'(CANVAS_X0 + CANVAS_W - 1);
    localparam logic [9:0] L_XRDEND = 10'(CANVAS_X0 + CANVAS_W - 2);
    localparam logic [9:0] L_XEND   = 10'(CANVAS_X0 + CANVAS_W);
    localparam logic [9:0] L_Y0     = 10'(CANVAS_Y0);
    localparam logic [9:0] L_YEND   = 10'(CANVAS_Y0 + CANVAS_H);

    localparam logic [ADDR_W-1:0] L_W    = ADDR_W'(CANVAS_W);
    localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(DEPTH - 1);

    clear_state_t      r_state, w_next_state;
    logic              w_clr_start;
    logic              r_armed;
    logic [ADDR_W-1:0] r_clr_addr;

    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_valid;

    logic              w_in_rows, w_in_cols, w_prefetch, w_rd_en, w_wr_hit;
    logic [9:0]        w_col_off;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [3:0]        w_ram_wdata, w_rd_data;

    assign w_in_rows  = (DrawY >= L_Y0) && (DrawY < L_YEND);
    assign w_in_cols  = (DrawX >= L_X0) && (DrawX < L_XEND);
    assign w_col_off  = DrawX - L_X0;
    assign w_prefetch = ram_read && (DrawX == L_XPRE);
    assign w_rd_en    = ram_read && (DrawX <= L_XRDEND);
    assign w_wr_hit   = ram_write && w_in_rows && w_in_cols && (r_state != CLEAR);

    // rd_ptr trails the address being fetched by one: the read issued while
    // the beam is on pixel x fetches pixel x+1 so it is registered in time.
    assign w_rd_addr  = w_prefetch ? r_line_base : r_rd_ptr + 1'b1;

    always_ff @(posedge vgaClk or posedge Reset) begin
        if (Reset) begin
            r_line_base <= '0;
            r_rd_ptr    <= '0;
            r_wr_addr   <= '0;
            r_wr_valid  <= 1'b0;
        end else begin
            // The bump after the last row overshoots the canvas; the next
            // frame's top border clears it before it is used again.
            if (DrawY < L_Y0)
                r_line_base <= '0;
            else if (w_in_rows && DrawX == L_XEND)
                r_line_base <= r_line_base + L_W;

            if (w_prefetch)
                r_rd_ptr <= r_line_base;
            else if (ram_read && DrawX < L_XLAST)
                r_rd_ptr <= r_rd_ptr + 1'b1;

            // Mapper data follows its strobe by a cycle; latch the address now.
            r_wr_valid <= w_wr_hit;
            if (w_wr_hit)
                r_wr_addr <= r_line_base + ADDR_W'(w_col_off);
        end
    end

    // Clear sequencer
    always_ff @(posedge vgaClk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
            r_armed    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_clr_start)
                r_clr_addr <= '0;
            else if (r_state == CLEAR)
                r_clr_addr <= r_clr_addr + 1'b1;
            // A held request must drop before it can start another clear.
            if (!clear_req)
                r_armed <= 1'b1;
            else if (w_clr_start)
                r_armed <= 1'b0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clr_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_req && r_armed) begin
                    w_next_state = CLEAR;
                    w_clr_start  = 1'b1;
                end
            end
            CLEAR: begin
                if (r_clr_addr == L_LAST) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Clear owns the write port; pending mapper writes are simply dropped.
    assign w_ram_we    = (r_state == CLEAR) || r_wr_valid;
    assign w_ram_waddr = (r_state == CLEAR) ? r_clr_addr : r_wr_addr;
    assign w_ram_wdata = (r_state == CLEAR) ? CLEAR_CODE : {ramIn2, ramIn};

    canvas_ram #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .RST_VAL (CLEAR_CODE)
    ) u_ram (
        .i_clk   (vgaClk),
        .i_rst   (Reset),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    assign clear_busy        = (r_state == CLEAR);
    assign {ramOut2, ramOut} = (r_state == CLEAR) ? CLEAR_CODE : w_rd_data;

endmodule

// File: tb/tb_canvas_store.sv
module tb_canvas_store;

    localparam int         X0    = 100;
    localparam int         Y0    = 100;
    localparam int         W     = 20;
    localparam int         H     = 10;
    localparam int         DEPTH = W * H;
    localparam int         AW    = 8;
    localparam logic [3:0] CC    = 4'b0100;

    logic       vgaClk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       ram_read, ram_write, clear_req;
    logic [1:0] ramIn, ramIn2, ramOut, ramOut2;
    logic       clear_busy;

    canvas_store #(
        .CANVAS_X0 (X0), .CANVAS_Y0 (Y0), .CANVAS_W (W), .CANVAS_H (H),
        .CLEAR_CODE (CC), .ADDR_W (AW)
    ) dut (
        .vgaClk (vgaClk), .Reset (Reset), .DrawX (DrawX), .DrawY (DrawY),
        .ram_read (ram_read), .ram_write (ram_write), .ramIn (ramIn),
        .ramIn2 (ramIn2), .clear_req (clear_req), .ramOut (ramOut),
        .ramOut2 (ramOut2), .clear_busy (clear_busy)
    );

    always #5 vgaClk = ~vgaClk;

    // reference canvas: pixel (x,y) lives at (y-Y0)*W + (x-X0)
    logic [3:0] mem [DEPTH];
    int errs   = 0;
    int checks = 0;

    // busy-cycle and clear-start counters, sampled on the falling edge
    int   busy_cnt = 0;
    int   rises    = 0;
    logic busy_q   = 1'b0;
    always @(negedge vgaClk) begin
        if (clear_busy === 1'b1) busy_cnt++;
        if (clear_busy === 1'b1 && busy_q !== 1'b1) rises++;
        busy_q = clear_busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vgaClk);
        #1;
    endtask

    function automatic logic [3:0] pixel_val(input int idx);
        logic [3:0] v;
        if (idx == 0)     return 4'b1010;
        if (idx == W - 1) return 4'b0011;
        v = 4'($urandom);
        if (v == CC) v = v ^ 4'h1;
        return v;
    endfunction

    // One raster frame: top-border cycle then nrows rows from DrawX=X0-2 to
    // X0+W+1. wr: strobe every column; (wx,wy): single write of 4'b1101;
    // rd: fetch and check canvas pixels; forced: a clear is running.
    task automatic run_frame(input bit wr, input bit rd, input int wx, input int wy,
                             input bit forced, input int nrows);
        bit         pend;
        int         pidx, y;
        logic [3:0] d, e, last;
        pend = 1'b0; pidx = 0; last = 4'h0;
        DrawY = 10'(Y0 - 1); DrawX = 10'(X0 + 5);
        ram_write = wr; ram_read = 1'b0;
        {ramIn2, ramIn} = 4'($urandom);
        tick();
        for (int r = 0; r < nrows; r++) begin
            for (int x = X0 - 2; x <= X0 + W + 1; x++) begin
                y = Y0 + r;
                DrawY = 10'(y); DrawX = 10'(x);
                ram_write = wr || (x == wx && y == wy);
                ram_read  = rd && x >= X0 - 1 && x <= X0 + W - 1;
                if (pend) d = (wx >= 0) ? 4'b1101 : pixel_val(pidx);
                else      d = 4'($urandom);
                {ramIn2, ramIn} = d;
                if (pend && !forced) mem[pidx] = d;
                if (rd && r < H && x >= X0 && x <= X0 + W - 1) begin
                    e = forced ? CC : mem[r * W + x - X0];
                    chk("rd_px", {ramOut2, ramOut}, e);
                    last = e;
                end else if (rd && r < H && x >= X0 + W) begin
                    chk("rd_hold", {ramOut2, ramOut}, last);
                end
                if (forced) chk("busy_in_clr", clear_busy, 1);
                pend = ram_write && r < H && x >= X0 && x < X0 + W;
                pidx = r * W + x - X0;
                tick();
            end
        end
        ram_write = 1'b0; ram_read = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (clear_busy === 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("clr_timeout", clear_busy, 0);
    endtask

    initial begin
        int base;
        Reset = 1'b1; DrawX = '0; DrawY = '0; ram_read = 1'b0; ram_write = 1'b0;
        ramIn = '0; ramIn2 = '0; clear_req = 1'b0;
        #2;
        chk("rst_ramOut", ramOut, 2'b00);
        chk("rst_ramOut2", ramOut2, 2'b01);
        chk("rst_busy", clear_busy, 0);
        tick(); tick();
        Reset = 1'b0;
        tick();

        // preload every pixel through the write path, then read it back
        run_frame(1'b1, 1'b0, -1, -1, 1'b0, H + 1);
        run_frame(1'b0, 1'b1, -1, -1, 1'b0, H);

        // async reset mid-line while the first pixel (1010) is on the outputs
        DrawY = 10'(Y0 - 1); DrawX = 10'(X0 + 5); tick();
        DrawY = 10'(Y0);
        for (int x = X0 - 2; x < X0; x++) begin
            DrawX = 10'(x); ram_read = (x >= X0 - 1); tick();
        end
        DrawX = 10'(X0);
        chk("pre_rst_px0", {ramOut2, ramOut}, 4'b1010);
        Reset = 1'b1; #1;
        chk("midline_rst_ramOut", ramOut, 2'b00);
        chk("midline_rst_ramOut2", ramOut2, 2'b01);
        chk("midline_rst_busy", clear_busy, 0);
        ram_read = 1'b0; tick();
        Reset = 1'b0; tick();

        // single write-back, visible the next frame; neighbours untouched
        run_frame(1'b0, 1'b1, X0 + 7, Y0 + 5, 1'b0, H);
        run_frame(1'b0, 1'b1, -1, -1, 1'b0, H);
        chk("single_wr_px", mem[5 * W + 7], 4'b1101);

        // pulsed clear with mapper traffic during it
        base = busy_cnt;
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        chk("clr_start_busy", clear_busy, 1);
        run_frame(1'b1, 1'b1, -1, -1, 1'b1, 3);
        wait_idle(2 * DEPTH);
        chk("clr_busy_cycles", busy_cnt - base, DEPTH);
        for (int i = 0; i < DEPTH; i++) mem[i] = CC;
        run_frame(1'b0, 1'b1, -1, -1, 1'b0, H);

        // held request runs exactly one clear; drop and re-raise starts another
        base = busy_cnt; rises = 0;
        clear_req = 1'b1;
        repeat (2 * DEPTH + 20) tick();
        chk("held_busy_cycles", busy_cnt - base, DEPTH);
        chk("held_starts", rises, 1);
        chk("held_idle", clear_busy, 0);
        clear_req = 1'b0; tick();
        clear_req = 1'b1; tick();
        chk("rearm_start", clear_busy, 1);
        clear_req = 1'b0;
        wait_idle(2 * DEPTH);
        chk("rearm_busy_cycles", busy_cnt - base, 2 * DEPTH);
        chk("rearm_starts", rises, 2);

        // reset partway through a clear leaves a partially cleared canvas
        run_frame(1'b1, 1'b0, -1, -1, 1'b0, H + 1);
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (50) tick();
        Reset = 1'b1; #1;
        chk("clr_rst_busy", clear_busy, 0);
        chk("clr_rst_out", {ramOut2, ramOut}, CC);
        for (int i = 0; i < 50; i++) mem[i] = CC;
        tick(); Reset = 1'b0; tick();
        chk("clr_rst_stays_idle", clear_busy, 0);
        run_frame(1'b0, 1'b1, -1, -1, 1'b0, H);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
